// File: rtl/vc_wrr_arbiter_pkg.sv
// Shared types and constants for the VC0/VC1 weighted round-robin arbiter.
// Holds the FSM state encoding and the virtual-channel identifiers.
package vc_wrr_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_SERVE0 = 2'd1,
    ARB_SERVE1 = 2'd2,
    ARB_HOLD   = 2'd3
  } arb_state_e;

  localparam logic VC0 = 1'b0;
  localparam logic VC1 = 1'b1;

endpackage

// File: rtl/vc_wrr_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear, used for per-VC grant statistics.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/vc_wrr_arbiter.sv
// Weighted round-robin pop scheduler between the VC0 and VC1 FIFOs.
// Pops are combinational; the mux select/valid tag is registered to line up with FIFO read data.
module vc_wrr_arbiter
  import vc_wrr_arbiter_pkg::*;
#(
  parameter int unsigned W_BITS = 4,
  parameter int unsigned W0_RST = 3,
  parameter int unsigned W1_RST = 1,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              VC0_empty,
  input  logic              VC1_empty,
  input  logic              D0_almost_full,
  input  logic              D1_almost_full,
  input  logic              cfg_wr,
  input  logic [W_BITS-1:0] cfg_w0,
  input  logic [W_BITS-1:0] cfg_w1,
  output logic              VC0_rd,
  output logic              VC1_rd,
  output logic              mux_sel,
  output logic              mux_valid,
  output logic [1:0]        arb_state,
  output logic [CNT_W-1:0]  grants_vc0,
  output logic [CNT_W-1:0]  grants_vc1
);

  localparam logic [W_BITS-1:0] ONE = W_BITS'(1);

  arb_state_e        state_q, state_d;
  arb_state_e        saved_q, saved_d;
  logic [W_BITS-1:0] credit_q, credit_d;
  logic              last_q, last_d;
  logic [W_BITS-1:0] w0_act_q, w0_act_d;
  logic [W_BITS-1:0] w1_act_q, w1_act_d;
  logic [W_BITS-1:0] w0_sh_q, w0_sh_d;
  logic [W_BITS-1:0] w1_sh_q, w1_sh_d;
  logic              pend_q, pend_d;
  logic              mux_sel_q, mux_sel_d;
  logic              mux_valid_q, mux_valid_d;

  logic              stall;
  logic              pop0;
  logic              pop1;
  logic              commit;
  logic              pick_vc0;
  logic [W_BITS-1:0] nxt_w0;
  logic [W_BITS-1:0] nxt_w1;

  // A zero weight still grants one pop per turn so neither VC can be starved.
  function automatic logic [W_BITS-1:0] eff_w(input logic [W_BITS-1:0] w);
    return (w == '0) ? ONE : w;
  endfunction

  // Destination is unknown before the pop, so either almost-full gates.
  assign stall = D0_almost_full | D1_almost_full;

  // Weight that a turn starting this cycle will use (pending shadow commits on entry).
  assign nxt_w0 = pend_q ? w0_sh_q : w0_act_q;
  assign nxt_w1 = pend_q ? w1_sh_q : w1_act_q;

  assign pick_vc0 = (last_q == VC1) ? !VC0_empty : VC1_empty;

  // State register
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= ARB_IDLE;
      saved_q     <= ARB_IDLE;
      credit_q    <= '0;
      last_q      <= VC1;
      w0_act_q    <= W_BITS'(W0_RST);
      w1_act_q    <= W_BITS'(W1_RST);
      w0_sh_q     <= W_BITS'(W0_RST);
      w1_sh_q     <= W_BITS'(W1_RST);
      pend_q      <= 1'b0;
      mux_sel_q   <= 1'b0;
      mux_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      saved_q     <= saved_d;
      credit_q    <= credit_d;
      last_q      <= last_d;
      w0_act_q    <= w0_act_d;
      w1_act_q    <= w1_act_d;
      w0_sh_q     <= w0_sh_d;
      w1_sh_q     <= w1_sh_d;
      pend_q      <= pend_d;
      mux_sel_q   <= mux_sel_d;
      mux_valid_q <= mux_valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    saved_d  = saved_q;
    credit_d = credit_q;
    last_d   = last_q;
    commit   = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (!VC0_empty || !VC1_empty) begin
          commit = 1'b1;
          if (pick_vc0) begin
            state_d  = ARB_SERVE0;
            credit_d = eff_w(nxt_w0);
          end else begin
            state_d  = ARB_SERVE1;
            credit_d = eff_w(nxt_w1);
          end
        end
      end
      ARB_SERVE0: begin
        if (stall) begin
          state_d = ARB_HOLD;
          saved_d = ARB_SERVE0;
        end else begin
          if (pop0) begin
            credit_d = credit_q - ONE;
            last_d   = VC0;
          end
          if (VC0_empty || (credit_q == ONE)) begin
            if (!VC1_empty) begin
              state_d  = ARB_SERVE1;
              credit_d = eff_w(nxt_w1);
              commit   = 1'b1;
            end else if (!VC0_empty) begin
              credit_d = eff_w(nxt_w0);
              commit   = 1'b1;
            end else begin
              state_d = ARB_IDLE;
            end
          end
        end
      end
      ARB_SERVE1: begin
        if (stall) begin
          state_d = ARB_HOLD;
          saved_d = ARB_SERVE1;
        end else begin
          if (pop1) begin
            credit_d = credit_q - ONE;
            last_d   = VC1;
          end
          if (VC1_empty || (credit_q == ONE)) begin
            if (!VC0_empty) begin
              state_d  = ARB_SERVE0;
              credit_d = eff_w(nxt_w0);
              commit   = 1'b1;
            end else if (!VC1_empty) begin
              credit_d = eff_w(nxt_w1);
              commit   = 1'b1;
            end else begin
              state_d = ARB_IDLE;
            end
          end
        end
      end
      ARB_HOLD: begin
        if (!stall) begin
          state_d = saved_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Shadow/active weights: a cfg_wr in the same cycle as a commit stays pending.
  always_comb begin
    w0_act_d = w0_act_q;
    w1_act_d = w1_act_q;
    w0_sh_d  = w0_sh_q;
    w1_sh_d  = w1_sh_q;
    pend_d   = pend_q;
    if (commit && pend_q) begin
      w0_act_d = w0_sh_q;
      w1_act_d = w1_sh_q;
      pend_d   = 1'b0;
    end
    if (cfg_wr) begin
      w0_sh_d = cfg_w0;
      w1_sh_d = cfg_w1;
      pend_d  = 1'b1;
    end
  end

  // Output logic
  always_comb begin
    pop0        = 1'b0;
    pop1        = 1'b0;
    if (!stall) begin
      if (state_q == ARB_SERVE0) begin
        pop0 = !VC0_empty;
      end
      if (state_q == ARB_SERVE1) begin
        pop1 = !VC1_empty;
      end
    end
    mux_valid_d = pop0 | pop1;
    mux_sel_d   = pop1;
  end

  assign VC0_rd    = pop0;
  assign VC1_rd    = pop1;
  assign mux_sel   = mux_sel_q;
  assign mux_valid = mux_valid_q;
  assign arb_state = state_q;

  sat_counter #(.CNT_W(CNT_W)) u_grants_vc0 (
    .clk   (clk),
    .rst_n (reset_L),
    .inc   (pop0),
    .clear (1'b0),
    .count (grants_vc0)
  );

  sat_counter #(.CNT_W(CNT_W)) u_grants_vc1 (
    .clk   (clk),
    .rst_n (reset_L),
    .inc   (pop1),
    .clear (1'b0),
    .count (grants_vc1)
  );

endmodule

// File: tb/tb_vc_wrr_arbiter.sv
// Directed self-checking bench for vc_wrr_arbiter with counter-based FIFO occupancy models.
// Grant counters are built narrow so saturation is reachable in a short run.
module tb_vc_wrr_arbiter;
  import vc_wrr_arbiter_pkg::*;

  localparam int unsigned W_BITS = 4;
  localparam int unsigned CNT_W  = 3;

  logic              clk;
  logic              reset_L;
  logic              VC0_empty;
  logic              VC1_empty;
  logic              D0_almost_full;
  logic              D1_almost_full;
  logic              cfg_wr;
  logic [W_BITS-1:0] cfg_w0;
  logic [W_BITS-1:0] cfg_w1;
  logic              VC0_rd;
  logic              VC1_rd;
  logic              mux_sel;
  logic              mux_valid;
  logic [1:0]        arb_state;
  logic [CNT_W-1:0]  grants_vc0;
  logic [CNT_W-1:0]  grants_vc1;

  int   loaded0, loaded1;
  int   pops0, pops1;
  int   cyc;
  int   pop_vc[$];
  int   pop_cyc[$];
  logic exp_mv, exp_ms;
  int   base;
  int   n_checks, n_fail;

  vc_wrr_arbiter #(
    .W_BITS (W_BITS),
    .W0_RST (3),
    .W1_RST (1),
    .CNT_W  (CNT_W)
  ) dut (
    .clk            (clk),
    .reset_L        (reset_L),
    .VC0_empty      (VC0_empty),
    .VC1_empty      (VC1_empty),
    .D0_almost_full (D0_almost_full),
    .D1_almost_full (D1_almost_full),
    .cfg_wr         (cfg_wr),
    .cfg_w0         (cfg_w0),
    .cfg_w1         (cfg_w1),
    .VC0_rd         (VC0_rd),
    .VC1_rd         (VC1_rd),
    .mux_sel        (mux_sel),
    .mux_valid      (mux_valid),
    .arb_state      (arb_state),
    .grants_vc0     (grants_vc0),
    .grants_vc1     (grants_vc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign VC0_empty = (pops0 >= loaded0);
  assign VC1_empty = (pops1 >= loaded1);

  // Expected mux tag: the pop request seen at the previous edge.
  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      exp_mv <= 1'b0;
      exp_ms <= 1'b0;
    end else begin
      exp_mv <= VC0_rd | VC1_rd;
      exp_ms <= VC1_rd;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (VC0_rd) begin
      pops0 <= pops0 + 1;
      pop_vc.push_back(0);
      pop_cyc.push_back(cyc);
    end
    if (VC1_rd) begin
      pops1 <= pops1 + 1;
      pop_vc.push_back(1);
      pop_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check("rd_exclusive", int'(VC0_rd & VC1_rd), 0);
    if (reset_L) begin
      check("mux_valid", int'(mux_valid), int'(exp_mv));
      if (exp_mv) check("mux_sel", int'(mux_sel), int'(exp_ms));
    end
  endtask

  task automatic start_test(input int n0, input int n1);
    reset_L        = 1'b0;
    D0_almost_full = 1'b0;
    D1_almost_full = 1'b0;
    cfg_wr         = 1'b0;
    tick();
    loaded0 = pops0 + n0;
    loaded1 = pops1 + n1;
    tick();
    reset_L = 1'b1;
    base    = pop_vc.size();
  endtask

  task automatic wait_pops(input int n, input int budget, input string tag);
    int i;
    i = 0;
    while ((pop_vc.size() < base + n) && (i < budget)) begin
      tick();
      i++;
    end
    check(tag, int'(pop_vc.size() >= base + n), 1);
  endtask

  // pat is read left to right: its most significant of n bits is the first pop.
  task automatic check_seq(input string tag, input logic [15:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      int idx;
      idx = n - 1 - i;
      if (base + i < pop_vc.size()) check(tag, pop_vc[base + i], int'(pat[idx]));
      else check(tag, -1, int'(pat[idx]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_L        = 1'b0;
    D0_almost_full = 1'b0;
    D1_almost_full = 1'b0;
    cfg_wr         = 1'b0;
    cfg_w0         = '0;
    cfg_w1         = '0;
    loaded0        = 0;
    loaded1        = 0;
    n_checks       = 0;
    n_fail         = 0;
    base           = 0;

    // 1: default weights 3/1, both VCs loaded
    start_test(8, 8);
    check("t1_reset_state", int'(arb_state), 0);
    check("t1_reset_rd", int'(VC0_rd | VC1_rd), 0);
    check("t1_reset_mux_valid", int'(mux_valid), 0);
    check("t1_reset_grants", int'(grants_vc0) + int'(grants_vc1), 0);
    tick();
    check("t1_enter_serve0", int'(arb_state), 1);
    wait_pops(8, 40, "t1_pops8");
    check_seq("t1_order", 16'(8'b00010001), 8);
    wait_pops(16, 60, "t1_drain");
    tick();
    tick();
    check("t1_idle_after_drain", int'(arb_state), 0);
    check("t1_grants_vc0_sat", int'(grants_vc0), 7);
    check("t1_grants_vc1_sat", int'(grants_vc1), 7);

    // 2: only VC1 loaded
    start_test(0, 4);
    wait_pops(4, 20, "t2_pops4");
    check_seq("t2_order", 16'(4'b1111), 4);
    check("t2_consecutive", pop_cyc[base + 3] - pop_cyc[base], 3);
    tick();
    tick();
    tick();
    check("t2_total_pops", pop_vc.size() - base, 4);
    check("t2_idle", int'(arb_state), 0);
    check("t2_grants_vc1", int'(grants_vc1), 4);
    check("t2_grants_vc0", int'(grants_vc0), 0);

    // 3: stall mid VC0 turn with credit 2
    start_test(8, 8);
    wait_pops(1, 10, "t3_first_pop");
    D0_almost_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold_state", int'(arb_state), 3);
      check("t3_hold_no_rd", int'(VC0_rd | VC1_rd), 0);
    end
    D0_almost_full = 1'b0;
    check("t3_no_pop_in_hold", pop_vc.size() - base, 1);
    wait_pops(5, 20, "t3_resume");
    check_seq("t3_order", 16'(5'b00010), 5);

    // 4: reweight to 1/2 during a VC0 turn
    start_test(8, 8);
    wait_pops(1, 10, "t4_first_pop");
    cfg_w0 = 4'd1;
    cfg_w1 = 4'd2;
    cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    wait_pops(9, 40, "t4_pops9");
    check_seq("t4_order", 16'(9'b000110110), 9);

    // 5: weight 0 on VC0 behaves as 1
    start_test(0, 0);
    cfg_w0 = 4'd0;
    cfg_w1 = 4'd1;
    cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    tick();
    check("t5_idle_when_empty", int'(arb_state), 0);
    loaded0 = pops0 + 6;
    loaded1 = pops1 + 6;
    wait_pops(6, 30, "t5_pops6");
    check_seq("t5_order", 16'(6'b010101), 6);

    // 6: asynchronous reset in the middle of a VC1 turn
    start_test(8, 8);
    begin
      int i;
      i = 0;
      while ((arb_state != 2'd2) && (i < 20)) begin
        tick();
        i++;
      end
    end
    check("t6_reached_serve1", int'(arb_state), 2);
    check("t6_vc1_rd_before", int'(VC1_rd), 1);
    check("t6_mux_valid_before", int'(mux_valid), 1);
    #2;
    reset_L = 1'b0;
    #1;
    check("t6_vc0_rd_async", int'(VC0_rd), 0);
    check("t6_vc1_rd_async", int'(VC1_rd), 0);
    check("t6_mux_valid_async", int'(mux_valid), 0);
    check("t6_mux_sel_async", int'(mux_sel), 0);
    check("t6_state_async", int'(arb_state), 0);
    check("t6_grants_async", int'(grants_vc0) + int'(grants_vc1), 0);
    tick();
    reset_L = 1'b1;
    base    = pop_vc.size();
    wait_pops(1, 10, "t6_pop_after_release");
    check_seq("t6_first_is_vc0", 16'(1'b0), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
